synth_io_harness: RTL and testbench
===================================

# synth_io_harness

Parametrised synthesis harness that lets a DUT with wide input and output buses be placed and timed on a device with few pins. It deserialises a framed bitstream into a double-buffered input word and captures the DUT's output bus into a register. The captured word is presented either as an XOR-reduction or as a serial shift-out. The block sits at the top level between the package pins and the DUT under synthesis/timing evaluation.

## Interface
Parameters:
- IN_WIDTH, 8, width of the deserialised DUT input word (≥1)
- OUT_WIDTH, 8, width of the captured DUT output word (≥1)
- OUT_MODE, 0, 0 = parity (pin_out is the XOR of the capture register), 1 = serial (pin_out is capture[0], shifted out by pin_shift)

Ports:
- clk  in  1  single clock; all state is updated on its rising edge
- rst  in  1  reset, asynchronous and active-high
- pin_in  in  1  serial data bit, LSB of word first
- pin_valid  in  1  pin_in is sampled this cycle
- pin_sync  in  1  frame alignment; clears the bit counter
- din  out  IN_WIDTH  double-buffered input word to DUT (keep attribute)
- din_update  out  1  one-cycle pulse: din changed this cycle
- dout  in  OUT_WIDTH  DUT output word
- pin_capture  in  1  load dout into capture register
- pin_shift  in  1  serial mode only: shift capture register right
- pin_out  out  1  observation pin

## Operation
- Reset (async assert, any time): sr, din, cnt, din_update and capture all clear to 0. pin_out therefore reads 0 in both modes. Reset mid-frame discards the partial frame.
- Input shift register sr[IN_WIDTH-1:0]:
  - On pin_valid, sr <= {pin_in, sr[IN_WIDTH-1:1]}.
  - The first bit of a frame therefore ends up at bit 0.
- Bit counter cnt, range 0..IN_WIDTH-1, width $clog2(IN_WIDTH)+1:
  - pin_valid with cnt==IN_WIDTH-1 completes the frame: din <= {pin_in, sr[IN_WIDTH-1:1]} (the shifted value), cnt <= 0, din_update <= 1.
  - pin_valid otherwise: cnt <= cnt+1.
  - pin_sync without pin_valid: cnt <= 0; sr and din are unchanged.
  - pin_sync together with pin_valid: the bit is the first bit of a new frame, so cnt <= 1. If IN_WIDTH==1, the frame completes instead (din updates, cnt <= 0).
- din_update is high for exactly one cycle per completed frame, otherwise 0.
- din holds its value between frames. It never shows partial frames.
- Capture register capture[OUT_WIDTH-1:0] (keep attribute):
  - pin_capture: capture <= dout.
  - OUT_MODE=1, pin_shift without pin_capture: capture <= {1'b0, capture[OUT_WIDTH-1:1]}.
  - pin_capture and pin_shift together: capture wins and no shift occurs.
  - OUT_MODE=0: pin_shift is ignored.
- pin_out is a combinational function of capture:
  - OUT_MODE=0: pin_out = ^capture.
  - OUT_MODE=1: pin_out = capture[0]. After OUT_WIDTH shifts with no new capture, pin_out reads 0.
- The input and output paths are independent. They may be active in the same cycle without interaction.

## Timing
- din and din_update change on the clock edge that samples the last bit of a frame. Latency from the last pin_valid to din visible is one edge.
- pin_out reflects a capture on the edge that samples pin_capture. In serial mode, each pin_shift edge presents the next bit.
- A 100% pin_valid duty cycle is supported: one frame every IN_WIDTH cycles, with din_update pulses IN_WIDTH cycles apart and no gaps.
- Reset deassertion: the first rising edge after rst falls may sample inputs.

## Test plan
- Framed load: IN_WIDTH=8, shift 0xA5 LSB first with continuous pin_valid -> din=0xA5 on the 8th edge, din_update high exactly 1 cycle, and din still 0x00 after 7 bits.
- Back-to-back frames: shift 0x3C then 0xC3 without a gap -> din 0x3C, then 0xC3; two din_update pulses 8 cycles apart.
- Sync realignment: shift 3 bits, then pin_sync alone, then 0x5A -> din=0x5A with one din_update. Also pin_sync together with pin_valid on the first bit of 0x81 -> din=0x81 after 8 bits total.
- Parity mode: OUT_MODE=0, OUT_WIDTH=8, dout=0x07 with pin_capture -> pin_out=1. Then dout=0x03 with pin_capture -> pin_out=0. pin_shift leaves pin_out unchanged.
- Serial mode: OUT_MODE=1, capture dout=0xB2, then 8 pin_shift pulses -> pin_out sequence 0,1,0,0,1,1,0,1, then 0. Capture and shift in the same cycle with dout=0x01 -> pin_out=1 with no shift.
- Async reset mid-frame: after 5 bits and a nonzero capture, pulse rst between clock edges -> din=0, din_update=0 and pin_out=0 immediately. The next 8 bits of 0xFF give din=0xFF.

Source files
------------

// File: rtl/synth_io_harness.sv
// synth_io_harness: pin-limited harness; pin_in/pin_valid/pin_sync deserialise into din (+din_update pulse), dout captured on pin_capture and observed on pin_out as parity (OUT_MODE=0) or serial shift-out via pin_shift (OUT_MODE=1)
module synth_io_harness #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8,
  parameter int OUT_MODE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pin_in,
  input  logic                 pin_valid,
  input  logic                 pin_sync,
  (* keep *) output logic [IN_WIDTH-1:0] din,
  output logic                 din_update,
  input  logic [OUT_WIDTH-1:0] dout,
  input  logic                 pin_capture,
  input  logic                 pin_shift,
  output logic                 pin_out
);
  localparam int CW = $clog2(IN_WIDTH) + 1;
  logic [IN_WIDTH-1:0] sr, sr_next;
  logic [CW-1:0] cnt;
  logic last;
  (* keep *) logic [OUT_WIDTH-1:0] capture;
  assign sr_next = (sr >> 1) | (IN_WIDTH'(pin_in) << (IN_WIDTH - 1));
  assign last = pin_valid && (pin_sync ? (IN_WIDTH == 1) : (cnt == CW'(IN_WIDTH - 1)));
  assign pin_out = (OUT_MODE == 1) ? capture[0] : ^capture;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr         <= '0;
      din        <= '0;
      cnt        <= '0;
      din_update <= 1'b0;
      capture    <= '0;
    end else begin
      din_update <= last;
      if (pin_valid) begin
        sr  <= sr_next;
        cnt <= last ? CW'(0) : pin_sync ? CW'(1) : cnt + CW'(1);
      end else if (pin_sync)
        cnt <= '0;
      if (last) din <= sr_next;
      if (pin_capture) capture <= dout;
      else if (OUT_MODE == 1 && pin_shift) capture <= capture >> 1;
    end
endmodule

// File: tb/tb_synth_io_harness.sv
// tb_synth_io_harness: table, hand-written and random checks of synth_io_harness in parity and serial modes
module tb_synth_io_harness;
  logic clk, rst, pin_in, pin_valid, pin_sync, pin_capture, pin_shift;
  logic [7:0] dout, din0, din1;
  logic upd0, upd1, p0, p1;
  int total = 0, passes = 0, fails = 0, cyc = 0;
  int upd_cycles[$];
  logic [7:0] m_din, m_acc, c0, c1;
  logic m_upd;
  int m_cnt;
  typedef struct {
    logic cap, shift;
    logic [7:0] dout;
    logic p0, p1;
  } vec_t;
  vec_t tbl[14];

  synth_io_harness #(.IN_WIDTH(8), .OUT_WIDTH(8), .OUT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .pin_in(pin_in), .pin_valid(pin_valid), .pin_sync(pin_sync),
    .din(din0), .din_update(upd0), .dout(dout), .pin_capture(pin_capture),
    .pin_shift(pin_shift), .pin_out(p0));
  synth_io_harness #(.IN_WIDTH(8), .OUT_WIDTH(8), .OUT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .pin_in(pin_in), .pin_valid(pin_valid), .pin_sync(pin_sync),
    .din(din1), .din_update(upd1), .dout(dout), .pin_capture(pin_capture),
    .pin_shift(pin_shift), .pin_out(p1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end else passes++;
  endtask

  task automatic model_reset();
    m_din = 0; m_acc = 0; m_upd = 0; m_cnt = 0; c0 = 0; c1 = 0;
  endtask

  // frame bits land at their arrival index; a full frame of IN_WIDTH bits becomes din
  task automatic model_step();
    m_upd = 0;
    if (pin_valid) begin
      if (pin_sync) m_cnt = 0;
      m_acc[m_cnt] = pin_in;
      m_cnt++;
      if (m_cnt == 8) begin
        m_din = m_acc;
        m_upd = 1;
        m_cnt = 0;
      end
    end else if (pin_sync) m_cnt = 0;
    if (pin_capture) begin
      c0 = dout;
      c1 = dout;
    end else if (pin_shift) c1 = c1 / 2;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (upd0) upd_cycles.push_back(cyc);
    chk("din0", din0, m_din);
    chk("din1", din1, m_din);
    chk("upd0", upd0, m_upd);
    chk("upd1", upd1, m_upd);
    chk("parity_out", p0, ^c0);
    chk("serial_out", p1, c1[0]);
  endtask

  task automatic idle();
    pin_valid = 0; pin_sync = 0; pin_in = 0; pin_capture = 0; pin_shift = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit s);
    for (int i = 0; i < n; i++) begin
      pin_valid = 1;
      pin_in = b[i];
      pin_sync = s && i == 0;
      tick();
    end
    idle();
  endtask

  initial begin
    tbl[0]  = '{1, 0, 8'h07, 1, 1};
    tbl[1]  = '{1, 0, 8'h03, 0, 1};
    tbl[2]  = '{0, 1, 8'h00, 0, 1};
    tbl[3]  = '{1, 0, 8'hB2, 0, 0};
    tbl[4]  = '{0, 1, 8'h00, 0, 1};
    tbl[5]  = '{0, 1, 8'h00, 0, 0};
    tbl[6]  = '{0, 1, 8'h00, 0, 0};
    tbl[7]  = '{0, 1, 8'h00, 0, 1};
    tbl[8]  = '{0, 1, 8'h00, 0, 1};
    tbl[9]  = '{0, 1, 8'h00, 0, 0};
    tbl[10] = '{0, 1, 8'h00, 0, 1};
    tbl[11] = '{0, 1, 8'h00, 0, 0};
    tbl[12] = '{1, 1, 8'h01, 1, 1};
    tbl[13] = '{0, 1, 8'h00, 1, 0};
    idle();
    dout = 0;
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_din", din0, 0);
    chk("reset_upd", upd0, 0);
    chk("reset_p0", p0, 0);
    chk("reset_p1", p1, 0);
    rst = 0;
    tick();
    // capture / shift table
    for (int i = 0; i < 14; i++) begin
      pin_capture = tbl[i].cap;
      pin_shift = tbl[i].shift;
      dout = tbl[i].dout;
      tick();
      chk($sformatf("tbl%0d_p0", i), p0, tbl[i].p0);
      chk($sformatf("tbl%0d_p1", i), p1, tbl[i].p1);
    end
    idle();
    // framed load of 0xA5
    send_bits(8'hA5, 7, 0);
    chk("a5_partial_din", din0, 8'h00);
    chk("a5_partial_upd", upd0, 0);
    pin_valid = 1; pin_in = 1;
    tick();
    idle();
    chk("a5_din", din0, 8'hA5);
    chk("a5_upd", upd0, 1);
    tick();
    chk("a5_upd_drop", upd0, 0);
    chk("a5_hold", din0, 8'hA5);
    // back-to-back frames
    upd_cycles.delete();
    send_bits(8'h3C, 8, 0);
    chk("b2b_first", din0, 8'h3C);
    send_bits(8'hC3, 8, 0);
    chk("b2b_second", din0, 8'hC3);
    chk("b2b_pulses", upd_cycles.size(), 2);
    if (upd_cycles.size() == 2) chk("b2b_gap", upd_cycles[1] - upd_cycles[0], 8);
    // sync alone realigns
    upd_cycles.delete();
    send_bits(8'h05, 3, 0);
    pin_sync = 1;
    tick();
    idle();
    send_bits(8'h5A, 8, 0);
    chk("sync_din", din0, 8'h5A);
    chk("sync_pulses", upd_cycles.size(), 1);
    // sync with the first valid bit
    send_bits(8'h07, 3, 0);
    send_bits(8'h81, 8, 1);
    chk("sync_valid_din", din0, 8'h81);
    // async reset mid-frame
    send_bits(8'h1F, 5, 0);
    pin_capture = 1; dout = 8'h01;
    tick();
    idle();
    chk("pre_rst_p0", p0, 1);
    @(negedge clk);
    rst = 1;
    #1;
    model_reset();
    chk("async_din", din0, 0);
    chk("async_upd", upd0, 0);
    chk("async_p0", p0, 0);
    chk("async_p1", p1, 0);
    #1 rst = 0;
    send_bits(8'hFF, 8, 0);
    chk("post_rst_din", din0, 8'hFF);
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      pin_valid = $urandom_range(0, 9) < 7;
      pin_sync = $urandom_range(0, 9) == 0;
      pin_in = 1'($urandom);
      pin_capture = $urandom_range(0, 9) < 2;
      pin_shift = $urandom_range(0, 9) < 4;
      dout = 8'($urandom);
      tick();
    end
    idle();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
